// File: rtl/cba_region_unpacker_pkg.sv
// Shared constants, lookup tables and the pure region-unpack function for the CBA end-of-column unpacker.
// The unpack function works on maximum-size vectors so one definition serves every parameter set.
package cba_region_unpacker_pkg;

    localparam logic [3:0] TOT_EMPTY   = 4'hF;
    localparam logic [3:0] TOT_MISSING = 4'hE;

    localparam int NPIX_MAX  = 64;
    localparam int SLOTS_MAX = 64;
    localparam int TB_MAX    = 8;

    // Readout order of the 16 pixels of a 4x4 region; identity for the current sensor.
    localparam int PIX_ORDER [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    localparam int REGION_MAP [16] = '{6, 4, 2, 0, 7, 5, 3, 1, 14, 12, 10, 8, 15, 13, 11, 9};

    typedef logic [TB_MAX-1:0]      code_t;
    typedef code_t [NPIX_MAX-1:0]   codes_t;

    function automatic int out_id_w(input int row_bits, input int rows);
        return row_bits + $clog2(rows);
    endfunction

    function automatic int word_w(input int rows, input int pix_per_row, input int tot_bits, input int slots);
        return slots * tot_bits + rows * pix_per_row;
    endfunction

    function automatic int pix_pos(input int i, input int npix);
        if (npix == 16 && i < 16) return PIX_ORDER[i];
        return i;
    endfunction

    // Hit pixels consume packed slots in ascending pixel order; excess hits are marked missing.
    function automatic codes_t unpack_region(input logic [NPIX_MAX-1:0]        hits,
                                             input logic [SLOTS_MAX*TB_MAX-1:0] slots,
                                             input int                          npix,
                                             input int                          nslots,
                                             input int                          tot_bits);
        codes_t c;
        code_t  empty_c;
        int     k;
        c       = '0;
        k       = 0;
        empty_c = TB_MAX'((1 << tot_bits) - 1);
        for (int i = 0; i < NPIX_MAX; i++) begin
            if (i < npix) begin
                if (hits[i]) begin
                    if (k < nslots) c[pix_pos(i, npix)] = slots[k*tot_bits +: TB_MAX] & empty_c;
                    else            c[pix_pos(i, npix)] = TB_MAX'(TOT_MISSING) & empty_c;
                    k++;
                end else begin
                    c[pix_pos(i, npix)] = empty_c;
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cba_region_unpacker_if.sv
// Column-readout input bus and per-row output bus of the region unpacker.
// master drives input words and downstream ready; slave is the unpacker itself.
interface cba_region_unpacker_if
    import cba_region_unpacker_pkg::*;
#(
    parameter int ROW_BITS    = 8,
    parameter int ROWS        = 4,
    parameter int PIX_PER_ROW = 4,
    parameter int TOT_BITS    = 4,
    parameter int TOT_SLOTS   = 8
);
    localparam int DATA_W = word_w(ROWS, PIX_PER_ROW, TOT_BITS, TOT_SLOTS);
    localparam int ID_W   = out_id_w(ROW_BITS, ROWS);
    localparam int ROW_W  = PIX_PER_ROW * TOT_BITS;

    logic [ROW_BITS-1:0] RowIdIn;
    logic                DataValidIn;
    logic [DATA_W-1:0]   DataIn;
    logic                InReady;
    logic [ID_W-1:0]     RowIdOut;
    logic                DataValidOut;
    logic                DataReadyOut;
    logic [ROW_W-1:0]    DataOut;
    logic                Busy;
    logic [15:0]         OverflowCnt;

    modport master (
        output RowIdIn, DataValidIn, DataIn, DataReadyOut,
        input  InReady, RowIdOut, DataValidOut, DataOut, Busy, OverflowCnt
    );

    modport slave (
        input  RowIdIn, DataValidIn, DataIn, DataReadyOut,
        output InReady, RowIdOut, DataValidOut, DataOut, Busy, OverflowCnt
    );

endinterface

// File: rtl/cba_region_unpacker_fifo.sv
// Word FIFO with registered full/empty flags; head is read combinationally, write-to-read latency 1 cycle.
// Writes while full are dropped and counted (saturating); a pop frees its slot only from the next cycle.
module cba_region_unpacker_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty,
    output logic [15:0]      ovf_cnt
);
    localparam int DB = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DB:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             push, pop;

    assign push   = wr_vld && !full;
    assign pop    = rd && !empty;
    assign wr_nxt = wr_ptr + (DB+1)'(push);
    assign rd_nxt = rd_ptr + (DB+1)'(pop);
    assign rd_dat = mem[rd_ptr[DB-1:0]];

    always_ff @(posedge Clk) begin
        if (push) mem[wr_ptr[DB-1:0]] <= wr_dat;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            ovf_cnt <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            // Extra pointer MSB distinguishes full from empty when the index bits match.
            full   <= (wr_nxt[DB] != rd_nxt[DB]) && (wr_nxt[DB-1:0] == rd_nxt[DB-1:0]);
            if (wr_vld && full && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/cba_region_unpacker.sv
// Expands buffered compressed region words into per-row ToT words, one row per cycle, skipping empty rows.
// Rows are presented combinationally from the FIFO head; a stalled row holds until DataReadyOut.
module cba_region_unpacker
    import cba_region_unpacker_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ROW_BITS    = 8,
    parameter int ROWS        = 4,
    parameter int PIX_PER_ROW = 4,
    parameter int TOT_BITS    = 4,
    parameter int TOT_SLOTS   = 8,
    parameter int MAP_MODE    = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    cba_region_unpacker_if.slave  bus
);
    localparam int NPIX   = ROWS * PIX_PER_ROW;
    localparam int SLOT_W = TOT_SLOTS * TOT_BITS;
    localparam int DATA_W = word_w(ROWS, PIX_PER_ROW, TOT_BITS, TOT_SLOTS);
    localparam int RB     = $clog2(ROWS);
    localparam int ROW_W  = PIX_PER_ROW * TOT_BITS;
    localparam int ID_W   = out_id_w(ROW_BITS, ROWS);
    localparam int FIFO_W = ROW_BITS + DATA_W;

    typedef enum logic {IDLE, SCAN} state_t;

    logic                        fifo_full, fifo_empty, fifo_pop;
    logic [FIFO_W-1:0]           head;
    logic [15:0]                 ovf_cnt;
    logic [ROW_BITS-1:0]         head_id;
    logic [NPIX-1:0]             head_hits;
    logic [SLOT_W-1:0]           head_slots;
    codes_t                      codes;
    logic [ROWS-1:0][ROW_W-1:0]  row_data;
    logic [ROWS-1:0]             row_ne;
    logic [RB-1:0]               rptr, sel;
    logic                        found, last, row_vld;
    logic [ID_W-1:0]             mapped_id;
    state_t                      state;
    logic                        unused_codes;

    cba_region_unpacker_fifo #(.DEPTH(DEPTH), .WIDTH(FIFO_W)) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_vld  (bus.DataValidIn),
        .wr_dat  ({bus.RowIdIn, bus.DataIn}),
        .full    (fifo_full),
        .rd      (fifo_pop),
        .rd_dat  (head),
        .empty   (fifo_empty),
        .ovf_cnt (ovf_cnt)
    );

    assign head_id    = head[FIFO_W-1 -: ROW_BITS];
    assign head_hits  = head[SLOT_W +: NPIX];
    assign head_slots = head[0 +: SLOT_W];

    assign codes = unpack_region(NPIX_MAX'(head_hits), (SLOTS_MAX*TB_MAX)'(head_slots),
                                 NPIX, TOT_SLOTS, TOT_BITS);
    assign unused_codes = ^codes;

    always_comb begin
        row_data = '0;
        row_ne   = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < PIX_PER_ROW; c++) begin
                row_data[r][c*TOT_BITS +: TOT_BITS] = codes[r*PIX_PER_ROW + c][TOT_BITS-1:0];
            end
            row_ne[r] = (row_data[r] != {ROW_W{1'b1}});
        end
    end

    // Lowest non-empty row at or after the row pointer, and whether it is the word's final one.
    always_comb begin
        found = 1'b0;
        last  = 1'b1;
        sel   = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_ne[i] && i >= int'(rptr)) begin
                if (!found) begin
                    found = 1'b1;
                    sel   = RB'(i);
                end else begin
                    last = 1'b0;
                end
            end
        end
    end

    // The registered empty flag is the IDLE/SCAN state; only the row pointer needs its own register.
    assign state    = fifo_empty ? IDLE : SCAN;
    assign row_vld  = (state == SCAN) && found;
    assign fifo_pop = (state == SCAN) && (!found || (bus.DataReadyOut && last));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rptr <= '0;
        end else if (fifo_pop) begin
            rptr <= '0;
        end else if (row_vld && bus.DataReadyOut) begin
            rptr <= sel + RB'(1);
        end
    end

    if (MAP_MODE == 1) begin : g_map_interleave
        logic [3:0] map_idx;
        assign map_idx   = {head_id[1:0], sel};
        assign mapped_id = {head_id[ROW_BITS-1:2], 4'(REGION_MAP[map_idx])};
    end else begin : g_map_linear
        assign mapped_id = {head_id, sel};
    end

    assign bus.DataValidOut = row_vld;
    assign bus.RowIdOut     = row_vld ? mapped_id : '0;
    assign bus.DataOut      = row_vld ? row_data[sel] : '0;
    assign bus.InReady      = !fifo_full;
    assign bus.Busy         = !fifo_empty || row_vld;
    assign bus.OverflowCnt  = ovf_cnt;

endmodule

// File: tb/tb_cba_region_unpacker.sv
// Scoreboard bench for cba_region_unpacker with default parameters (linear row mapping).
module tb_cba_region_unpacker;

    logic Clk = 1'b0;
    logic Reset;

    cba_region_unpacker_if bus ();

    cba_region_unpacker dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0]  id;
        logic [15:0] dat;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference expansion: hits take slots in pixel order, hits past slot 8 read 4'hE, misses 4'hF.
    function automatic void model_word(input logic [7:0] id, input logic [15:0] hm, input logic [31:0] slots);
        logic [3:0]  code [16];
        logic [15:0] row;
        exp_t        e;
        int          k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (hm[i]) begin
                code[i] = (k < 8) ? slots[4*k +: 4] : 4'hE;
                k++;
            end else begin
                code[i] = 4'hF;
            end
        end
        for (int r = 0; r < 4; r++) begin
            row = {code[4*r+3], code[4*r+2], code[4*r+1], code[4*r]};
            if (row != 16'hFFFF) begin
                e.id  = {id, 2'(r)};
                e.dat = row;
                sb.push_back(e);
            end
        end
    endfunction

    logic        prev_stall = 1'b0;
    logic [9:0]  prev_id;
    logic [15:0] prev_dat;

    always @(negedge Clk) begin
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", 32'(bus.DataValidOut), 32'd1);
                check("hold_id",  32'(bus.RowIdOut),     32'(prev_id));
                check("hold_dat", 32'(bus.DataOut),      32'(prev_dat));
            end
            if (bus.DataValidOut && bus.DataReadyOut) begin
                if (sb.size() == 0) begin
                    check("extra_row", 32'(sb.size()), 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("row_id",  32'(bus.RowIdOut), 32'(mon_e.id));
                    check("row_dat", 32'(bus.DataOut),  32'(mon_e.dat));
                end
            end
            prev_stall = bus.DataValidOut && !bus.DataReadyOut;
            prev_id    = bus.RowIdOut;
            prev_dat   = bus.DataOut;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_word(input logic [7:0] id, input logic [15:0] hm, input logic [31:0] slots,
                              input bit expect_accept);
        bus.RowIdIn     = id;
        bus.DataIn      = {hm, slots};
        bus.DataValidIn = 1'b1;
        if (expect_accept) model_word(id, hm, slots);
        tick();
        bus.DataValidIn = 1'b0;
    endtask

    // Counts negedges with Busy high until the DUT goes idle, bounded.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge Clk);
        while (bus.Busy && cyc < 500) begin
            cyc++;
            @(negedge Clk);
        end
        if (cyc >= 500) check("idle_timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100us");
        $fatal(1);
    end

    initial begin
        int c;
        int nrows;
        logic [15:0] hm;
        logic [31:0] sl;

        Reset            = 1'b1;
        bus.RowIdIn      = '0;
        bus.DataIn       = '0;
        bus.DataValidIn  = 1'b0;
        bus.DataReadyOut = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_vld",   32'(bus.DataValidOut), 32'd0);
        check("rst_dat",   32'(bus.DataOut),      32'd0);
        check("rst_id",    32'(bus.RowIdOut),     32'd0);
        check("rst_inrdy", 32'(bus.InReady),      32'd1);
        check("rst_busy",  32'(bus.Busy),         32'd0);
        check("rst_ovf",   32'(bus.OverflowCnt),  32'd0);

        // Single hit pixel 0: visible the cycle after the write, then gone.
        tick();
        bus.RowIdIn     = 8'h12;
        bus.DataIn      = {16'h0001, 32'h0000_0003};
        bus.DataValidIn = 1'b1;
        model_word(8'h12, 16'h0001, 32'h0000_0003);
        @(negedge Clk);
        check("t1_lat_write_cycle", 32'(bus.DataValidOut), 32'd0);
        tick();
        bus.DataValidIn = 1'b0;
        @(negedge Clk);
        check("t1_lat_next_cycle", 32'(bus.DataValidOut), 32'd1);
        wait_idle(c);
        check("t1_drain_cycles", 32'(c), 32'd0);

        // Full hitmap: four rows on consecutive cycles, rows 2-3 marked missing.
        tick();
        drive_word(8'h5A, 16'hFFFF, 32'h8765_4321, 1'b1);
        wait_idle(c);
        check("t2_row_cycles", 32'(c), 32'd4);
        check("t2_sb_left", 32'(sb.size()), 32'd0);

        // Empty hitmap: popped in one cycle without output.
        tick();
        drive_word(8'h33, 16'h0000, 32'h1234_5678, 1'b1);
        wait_idle(c);
        check("t3_pop_cycles", 32'(c), 32'd1);
        check("t3_busy", 32'(bus.Busy), 32'd0);

        // Overfill with downstream stalled, then drain without bubbles.
        tick();
        bus.DataReadyOut = 1'b0;
        for (int i = 0; i < 17; i++) begin
            hm = 16'($urandom) | 16'h0001;
            sl = $urandom & 32'h7777_7777;
            drive_word(8'h80 + 8'(i), hm, sl, i < 16);
        end
        @(negedge Clk);
        check("t4_inrdy_full", 32'(bus.InReady), 32'd0);
        check("t4_ovf", 32'(bus.OverflowCnt), 32'd1);
        nrows = sb.size();
        tick();
        bus.DataReadyOut = 1'b1;
        wait_idle(c);
        check("t4_drain_cycles", 32'(c), 32'(nrows));
        check("t4_sb_left", 32'(sb.size()), 32'd0);
        check("t4_inrdy_after", 32'(bus.InReady), 32'd1);

        // Ready toggling every cycle across a four-row word.
        tick();
        bus.DataReadyOut = 1'b0;
        drive_word(8'hC3, 16'hFFFF, 32'h0123_4567, 1'b1);
        for (int i = 0; i < 100 && bus.Busy; i++) begin
            bus.DataReadyOut = !bus.DataReadyOut;
            tick();
        end
        check("t5_sb_left", 32'(sb.size()), 32'd0);
        check("t5_busy", 32'(bus.Busy), 32'd0);

        // Reset in the middle of a word with eight buffered.
        bus.DataReadyOut = 1'b0;
        for (int i = 0; i < 8; i++) drive_word(8'(i), 16'h0F0F, 32'h1111_2222, 1'b1);
        bus.DataReadyOut = 1'b1;
        tick();
        bus.DataReadyOut = 1'b0;
        @(negedge Clk);
        check("t6_busy_before", 32'(bus.Busy), 32'd1);
        check("t6_ovf_before", 32'(bus.OverflowCnt), 32'd1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sb.delete();
        @(negedge Clk);
        check("t6_vld", 32'(bus.DataValidOut), 32'd0);
        check("t6_busy", 32'(bus.Busy), 32'd0);
        check("t6_ovf", 32'(bus.OverflowCnt), 32'd0);
        check("t6_inrdy", 32'(bus.InReady), 32'd1);

        // Row pointer must restart at row 0 after the reset.
        tick();
        bus.DataReadyOut = 1'b1;
        drive_word(8'hA5, 16'h0001, 32'h0000_0009, 1'b1);
        wait_idle(c);
        check("t6_post_cycles", 32'(c), 32'd1);
        check("t6_post_sb_left", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
